cfg_chain_loader: RTL
=====================

// Module: cfg_chain_loader
// PURPOSE
//  Upstream feeder for the CB/LE dual-bank config shift chains. Accepts packed bitstream words over valid/ready
//  and shifts them serially, one A/B bit pair per cycle, into config_data_inA/B of the first tile.
//  Holds config_en high for the whole session so downstream CBs keep LE inputs and bus outputs at 0.
//  Reports done/err to the top-level programming controller.
// PARAMETERS
//  WORD_W     8   input word width; must be even; carries WORD_W/2 A/B pairs
//  CHAIN_LEN  30  bits per bank in the full chain (sum of all tiles; one default CB = 6*5)
// PORTS
//  clk        in   1       clock
//  nrst       in   1       reset, asynchronous, active-low
//  start      in   1       begin session (sampled in IDLE only)
//  in_data    in   WORD_W  bitstream word; bit 2k = bank A, bit 2k+1 = bank B, pair k shifted in order k=0..
//  in_valid   in   1       in_data valid
//  in_ready   out  1       loader accepts word this cycle
//  config_en  out  1       chain config enable to all tiles
//  shift_en   out  1       chain en strobe; chain shifts when shift_en && config_en
//  cfg_outA   out  1       serial data to chain bank A (config_data_inA of first tile)
//  cfg_outB   out  1       serial data to chain bank B
//  busy       out  1       session in progress
//  done       out  1       one-cycle pulse at session end
//  err        out  1       sticky until next start; checksum mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-session aborts immediately; chain left partial.
//  FSM IDLE -> LOAD -> SHIFT -> (LOAD | CHECK | DONE) -> IDLE.
//  IDLE: start=1 -> LOAD next cycle; err cleared, busy=1, config_en=1 from that cycle on.
//  LOAD: in_ready=1. in_valid&&in_ready latches word into shift reg -> SHIFT next cycle. No valid: wait, config_en held.
//  SHIFT: shift_en=1 every cycle; cfg_outA/B = current pair (LSB pair first), reg shifts right by 2.
//    Runs min(WORD_W/2, remaining) cycles; pair counter (clog2(CHAIN_LEN+1) bits) counts to CHAIN_LEN.
//    Last word: unused upper pairs discarded, never shifted. Counter hits CHAIN_LEN -> CHECK (if macro) else DONE.
//    Otherwise -> LOAD. in_ready=0 throughout SHIFT (one bubble per word; no skid buffer).
//  DONE: done=1 one cycle, config_en=0, shift_en=0, busy=0 -> IDLE. cfg_outA/B=0 outside SHIFT.
//  start while busy ignored; start and done same cycle impossible (done only in DONE, start sampled in IDLE).
//  First pair shifted ends at chain tail (MSB end); host sends bitstream tail-first.
//  Words needed = ceil(CHAIN_LEN/(WORD_W/2)); default 8 words, 30 shift cycles, 38 cycles min LOAD+SHIFT.
// CONFIGURATION
//  CFG_CHECKSUM_EN defined: running XOR parA/parB of all shifted A/B bits; after last data pair enter CHECK:
//    in_ready=1, one extra word accepted; in_data[0]!=parA or in_data[1]!=parB -> err=1. Then DONE.
//    Other checksum bits ignored. config_en stays 1 during CHECK.
//  Not defined: no CHECK state, no checksum word; err tied 0.
// TESTING
//  1 reset: nrst=0 -> all outputs 0; release, idle 10 cycles -> config_en=0, in_ready=0.
//  2 full load defaults: start, 8 words 0x1B.. pattern -> exactly 30 shift_en cycles, pair order matches
//    LSB-first, last word pairs 2,3 not shifted; done pulse 1 cycle; 30-bit CB model contents match.
//  3 backpressure: in_valid low 5 cycles between words -> config_en stays 1, no shift_en, data intact.
//  4 reset mid-SHIFT (after 12 pairs) -> next cycle config_en=0, busy=0; new start reloads fully.
//  5 start pulsed while busy -> ignored; pair count still 30, single done.
//  6 CFG_CHECKSUM_EN: correct parity word -> err=0; flipped bit0 -> err=1 with done; err clears on next start.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// -----------------------------------------------------------------------------
// cfg_chain_loader
//   Upstream feeder for the CB/LE dual-bank configuration shift chains. Packed
//   bitstream words arrive over a valid/ready handshake and are shifted out
//   serially, one A/B bit pair per cycle, into the first tile's
//   config_data_inA/B. config_en stays high for the whole session so that
//   downstream CBs hold LE inputs and bus outputs at 0 while they are
//   reconfigured.
//
//   Build option: CFG_CHECKSUM_EN
//     defined   - after the last data pair one extra word is accepted; its
//                 bit 0 / bit 1 must equal the running XOR of all shifted
//                 A / B bits, otherwise err is raised (sticky until next start).
//     undefined - no checksum word, err is tied to 0.
//
// Parameters
//   WORD_W     input word width (even), carries WORD_W/2 A/B pairs
//   CHAIN_LEN  bits per bank in the complete chain
//
// Ports
//   clk        in   clock
//   nrst       in   asynchronous active-low reset
//   start      in   begin a session (only looked at while idle)
//   in_data    in   bitstream word; bit 2k = bank A, bit 2k+1 = bank B
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a word this cycle
//   config_en  out  chain configuration enable to all tiles
//   shift_en   out  chain shift strobe
//   cfg_outA   out  serial data to chain bank A
//   cfg_outB   out  serial data to chain bank B
//   busy       out  session in progress
//   done       out  one-cycle pulse at session end
//   err        out  checksum mismatch, sticky until next start
// -----------------------------------------------------------------------------
module cfg_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 30
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              config_en,
    output logic              shift_en,
    output logic              cfg_outA,
    output logic              cfg_outB,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PAIRS = WORD_W / 2;
    localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int CW    = $clog2(CHAIN_LEN + 1);

    localparam logic [PW-1:0] LAST_PAIR = PW'(PAIRS - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
`ifdef CFG_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q,  sreg_d;    // word being shifted, LSB pair first
    logic [CW-1:0]     cnt_q,   cnt_d;     // pairs shifted this session
    logic [PW-1:0]     pair_q,  pair_d;    // pair index within current word

`ifdef CFG_CHECKSUM_EN
    logic par_a_q, par_a_d;
    logic par_b_q, par_b_d;
    logic err_q,   err_d;
`endif

    // NOTE: every register is reset, including the data shift register, so a
    // reset mid-session leaves no stale word that could leak into a new load.
    // NOTE: sequential state uses non-blocking assignments only; blocking here
    // would make the result depend on process evaluation order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            pair_q  <= '0;
`ifdef CFG_CHECKSUM_EN
            par_a_q <= 1'b0;
            par_b_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
`ifdef CFG_CHECKSUM_EN
            par_a_q <= par_a_d;
            par_b_q <= par_b_d;
            err_q   <= err_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        in_ready  = 1'b0;
        config_en = 1'b0;
        shift_en  = 1'b0;
        cfg_outA  = 1'b0;
        cfg_outB  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef CFG_CHECKSUM_EN
        par_a_d   = par_a_q;
        par_b_d   = par_b_q;
        err_d     = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    pair_d  = '0;
`ifdef CFG_CHECKSUM_EN
                    par_a_d = 1'b0;
                    par_b_d = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end

            S_LOAD: begin
                in_ready  = 1'b1;
                config_en = 1'b1;
                busy      = 1'b1;
                if (in_valid) begin
                    sreg_d  = in_data;
                    pair_d  = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                config_en = 1'b1;
                busy      = 1'b1;
                shift_en  = 1'b1;
                cfg_outA  = sreg_q[0];
                cfg_outB  = sreg_q[1];
                sreg_d    = sreg_q >> 2;
                cnt_d     = cnt_q + CW'(1);
                pair_d    = pair_q + PW'(1);
`ifdef CFG_CHECKSUM_EN
                par_a_d   = par_a_q ^ sreg_q[0];
                par_b_d   = par_b_q ^ sreg_q[1];
`endif
                // Chain-full wins over end-of-word: unused upper pairs of the
                // final word are simply dropped.
                if (cnt_q == LAST_BIT) begin
`ifdef CFG_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else if (pair_q == LAST_PAIR) begin
                    state_d = S_LOAD;
                end
            end

`ifdef CFG_CHECKSUM_EN
            S_CHECK: begin
                in_ready  = 1'b1;
                config_en = 1'b1;
                busy      = 1'b1;
                if (in_valid) begin
                    err_d   = (in_data[0] != par_a_q) || (in_data[1] != par_b_q);
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

`ifdef CFG_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
